// File: rtl/fifo_burst_reader_if.sv
// fifo_burst_reader_if: control, FIFO read-side and output stream signals of the burst reader.
interface fifo_burst_reader_if #(
   parameter int WIDTH = 8,
   parameter int CW = 4
);
   logic start;
   logic [CW-1:0] count;
   logic fifo_deq;
   logic [WIDTH-1:0] fifo_data_out;
   logic fifo_empty;
   logic m_valid;
   logic m_ready;
   logic [WIDTH-1:0] m_data;
   logic busy;
   logic done;
   logic [CW-1:0] words_out;
   modport master (
      input start, count, fifo_data_out, fifo_empty, m_ready,
      output fifo_deq, m_valid, m_data, busy, done, words_out
   );
   modport slave (
      output start, count, fifo_data_out, fifo_empty, m_ready,
      input fifo_deq, m_valid, m_data, busy, done, words_out
   );
endinterface

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: drains a programmed number of FIFO words into a valid/ready stream
// through a 2-entry skid buffer that hides the FIFO's one-cycle read latency.
module fifo_burst_reader #(
   parameter int WIDTH = 8,
   parameter int CW = 4
) (
   input logic clk,
   input logic reset,
   fifo_burst_reader_if.master bus
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state;
   logic [CW-1:0] remaining, total;
   logic [1:0] occ, base;
   logic inflight, pop, deq;
   logic [2:0] level;
   logic [WIDTH-1:0] b0, b1, n0, n1;
   assign pop = bus.m_valid && bus.m_ready;
   // occupancy the buffer will have once this cycle's capture and pop settle
   assign level = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
   assign deq = state == RUN && !bus.fifo_empty && remaining != '0 && level < 3'd2;
   assign bus.fifo_deq = deq;
   assign bus.m_valid = occ != 2'd0;
   assign bus.m_data = b0;
   always_comb begin
      base = occ - {1'b0, pop};
      n0 = inflight && base == 2'd0 ? bus.fifo_data_out : pop ? b1 : b0;
      n1 = inflight && base != 2'd0 ? bus.fifo_data_out : b1;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         remaining <= '0;
         total <= '0;
         occ <= 2'd0;
         inflight <= 1'b0;
         b0 <= '0;
         b1 <= '0;
         bus.busy <= 1'b0;
         bus.done <= 1'b0;
         bus.words_out <= '0;
      end else begin
         occ <= level[1:0];
         inflight <= deq;
         b0 <= n0;
         b1 <= n1;
         if (deq) remaining <= remaining - 1'b1;
         if (pop) bus.words_out <= bus.words_out + 1'b1;
         case (state)
            IDLE: if (bus.start) begin
               remaining <= bus.count;
               total <= bus.count;
               bus.words_out <= '0;
               bus.busy <= 1'b1;
               bus.done <= bus.count == '0;
               state <= bus.count == '0 ? DONE : RUN;
            end
            RUN: if (pop && CW'(bus.words_out + 1'b1) == total) begin
               bus.done <= 1'b1;
               state <= DONE;
            end
            default: begin
               bus.busy <= 1'b0;
               bus.done <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb_fifo_burst_reader: FIFO model plus scoreboard of expected stream words,
// a table of burst vectors and hand-written corner-case sequences.
module tb_fifo_burst_reader;
   localparam int W = 8;
   localparam int C = 4;
   typedef struct {
      int n;
      bit rnd;
      int exp_words;
      int exp_deq;
   } vec_t;
   logic clk = 1'b0;
   logic reset;
   fifo_burst_reader_if #(.WIDTH(W), .CW(C)) bus();
   fifo_burst_reader #(.WIDTH(W), .CW(C)) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   logic [W-1:0] fq[$], src[$], exp_q[$];
   int owed = 0, pass_cnt = 0, total = 0, deqs = 0, dones = 0, hs = 0;
   bit pv = 0;
   logic [W-1:0] pd;
   function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
      total++;
      if (act === req) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, req);
   endfunction
   always @(posedge clk) begin
      if (bus.fifo_deq && fq.size() != 0) bus.fifo_data_out <= fq.pop_front();
      bus.fifo_empty <= fq.size() == 0;
   end
   always @(negedge clk) begin
      #4;
      if (reset) pv = 0;
      else begin
         if (bus.fifo_deq) deqs++;
         if (bus.done) dones++;
         if (bus.fifo_deq && bus.fifo_empty) begin
            total++;
            $display("FAIL deq_when_empty: deq issued with fifo_empty=1");
         end
         if (pv) begin
            chk("hold_valid", bus.m_valid, 1);
            chk("hold_data", bus.m_data, pd);
         end
         if (bus.m_valid && bus.m_ready) begin
            hs++;
            if (exp_q.size() == 0) begin
               total++;
               $display("FAIL sb_extra: unexpected word %0h, none required", bus.m_data);
            end else chk("m_data", bus.m_data, exp_q.pop_front());
         end
         pv = bus.m_valid && !bus.m_ready;
         pd = bus.m_data;
      end
   end
   task automatic push(input logic [W-1:0] v);
      fq.push_back(v);
      if (owed > 0) begin
         exp_q.push_back(v);
         owed--;
      end else src.push_back(v);
   endtask
   task automatic start_burst(input int n);
      @(negedge clk);
      bus.count = C'(n);
      bus.start = 1'b1;
      deqs = 0;
      dones = 0;
      for (int i = 0; i < n; i++)
         if (src.size() != 0) exp_q.push_back(src.pop_front());
         else owed++;
      @(negedge clk);
      bus.start = 1'b0;
   endtask
   task automatic wait_done(input int lim, input bit rnd);
      int k = 0;
      while (!bus.done && k < lim) begin
         @(negedge clk);
         if (rnd) bus.m_ready = 1'($urandom_range(0, 1));
         k++;
      end
      chk("done_seen", bus.done, 1);
      bus.m_ready = 1'b1;
   endtask
   vec_t tbl[6];
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      tbl[0] = '{1, 0, 1, 1};
      tbl[1] = '{3, 0, 3, 3};
      tbl[2] = '{0, 0, 0, 0};
      tbl[3] = '{15, 0, 15, 15};
      tbl[4] = '{7, 1, 7, 7};
      tbl[5] = '{2, 1, 2, 2};
      reset = 1'b1;
      bus.start = 1'b0;
      bus.count = '0;
      bus.m_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_deq", bus.fifo_deq, 0);
      chk("rst_valid", bus.m_valid, 0);
      chk("rst_data", bus.m_data, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_words", bus.words_out, 0);
      reset = 1'b0;
      // basic burst: deq on cycles 1..3 after start, data from cycle 3
      push(8'h11); push(8'h22); push(8'h33);
      repeat (2) @(negedge clk);
      start_burst(3);
      chk("b_deq1", bus.fifo_deq, 1);
      chk("b_val1", bus.m_valid, 0);
      @(negedge clk);
      chk("b_deq2", bus.fifo_deq, 1);
      chk("b_val2", bus.m_valid, 0);
      @(negedge clk);
      chk("b_deq3", bus.fifo_deq, 1);
      chk("b_data3", {bus.m_valid, bus.m_data}, 9'h111);
      @(negedge clk);
      chk("b_deq4", bus.fifo_deq, 0);
      chk("b_data4", {bus.m_valid, bus.m_data}, 9'h122);
      wait_done(20, 0);
      @(negedge clk);
      chk("b_busy", bus.busy, 0);
      chk("b_words", bus.words_out, 3);
      chk("b_dones", dones, 1);
      chk("b_deqs", deqs, 3);
      foreach (tbl[v]) begin
         for (int i = 0; i < tbl[v].n; i++) push(8'($urandom_range(0, 255)));
         repeat (2) @(negedge clk);
         start_burst(tbl[v].n);
         wait_done(300, tbl[v].rnd);
         @(negedge clk);
         chk("t_words", bus.words_out, tbl[v].exp_words);
         chk("t_deqs", deqs, tbl[v].exp_deq);
         chk("t_dones", dones, 1);
         chk("t_busy", bus.busy, 0);
         chk("t_sb_empty", exp_q.size(), 0);
      end
      // backpressure: two deqs fill the buffer, then head is held
      for (int i = 0; i < 5; i++) push(8'h50 + 8'(i));
      repeat (2) @(negedge clk);
      bus.m_ready = 1'b0;
      start_burst(5);
      repeat (5) @(negedge clk);
      chk("bp_deqs", deqs, 2);
      chk("bp_head", {bus.m_valid, bus.m_data}, 9'h150);
      bus.m_ready = 1'b1;
      wait_done(50, 0);
      @(negedge clk);
      chk("bp_words", bus.words_out, 5);
      chk("bp_sb_empty", exp_q.size(), 0);
      // empty stall: only one word present, burst waits in RUN
      push(8'hA0);
      repeat (2) @(negedge clk);
      start_burst(3);
      repeat (10) @(negedge clk);
      chk("es_busy", bus.busy, 1);
      chk("es_deqs", deqs, 1);
      chk("es_deq_now", bus.fifo_deq, 0);
      push(8'hA1); push(8'hA2);
      wait_done(50, 0);
      @(negedge clk);
      chk("es_words", bus.words_out, 3);
      chk("es_sb_empty", exp_q.size(), 0);
      // second start during a burst is ignored
      for (int i = 0; i < 4; i++) push(8'hC0 + 8'(i));
      repeat (2) @(negedge clk);
      start_burst(4);
      bus.count = 4'd2;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done(50, 0);
      repeat (4) @(negedge clk);
      chk("ig_words", bus.words_out, 4);
      chk("ig_deqs", deqs, 4);
      chk("ig_dones", dones, 1);
      chk("ig_busy", bus.busy, 0);
      // asynchronous reset after two of four words
      for (int i = 0; i < 6; i++) push(8'hE0 + 8'(i));
      repeat (2) @(negedge clk);
      hs = 0;
      start_burst(4);
      for (int k = 0; k < 50 && hs < 2; k++) @(negedge clk);
      chk("rs_two_words", hs >= 2, 1);
      #2 reset = 1'b1;
      #1;
      chk("rs_deq", bus.fifo_deq, 0);
      chk("rs_valid", bus.m_valid, 0);
      chk("rs_data", bus.m_data, 0);
      chk("rs_busy", bus.busy, 0);
      chk("rs_done", bus.done, 0);
      chk("rs_words", bus.words_out, 0);
      exp_q.delete();
      owed = 0;
      src = fq;
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      start_burst(2);
      wait_done(50, 0);
      @(negedge clk);
      chk("rs2_words", bus.words_out, 2);
      chk("rs2_deqs", deqs, 2);
      chk("rs2_sb_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule

// File: doc/fifo_burst_reader.md
Name: fifo_burst_reader

Overview:
Read-side controller for the 8-bit FIFO. On a start pulse it drains a programmed number of words from the FIFO by driving the FIFO's deq input. It hides the FIFO's one-cycle read latency behind a 2-entry skid buffer and presents the words on a valid/ready stream to downstream logic. It reports busy/done and an accepted-word count, and is the counterpart of the writer that drives enq/data_in.

Parameters:
WIDTH, 8, data width; matches FIFO data_in/data_out.
CW, 4, width of count and words_out; max burst 2^CW-1.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse; begins a burst when idle
count  input  CW  burst length, sampled on accepted start
fifo_deq  output  1  read strobe to FIFO deq
fifo_data_out  input  WIDTH  FIFO data_out; valid the cycle after fifo_deq, held until the next deq
fifo_empty  input  1  FIFO empty flag
m_valid  output  1  stream word valid
m_ready  input  1  downstream accepts when m_valid&&m_ready
m_data  output  WIDTH  stream data; head of skid buffer
busy  output  1  high while state != IDLE
done  output  1  one-cycle pulse at burst completion
words_out  output  CW  words accepted downstream in the current/last burst

Behaviour:
- Clock and reset: one clock. Reset is asynchronous, active-high. Reset forces:
  - fifo_deq=0, m_valid=0, m_data=0, busy=0, done=0, words_out=0
  - buffer empty, in-flight flag 0, state IDLE
- Reset mid-burst: a word in flight from the FIFO is discarded, and the remaining count is lost.
- States: IDLE, RUN, DONE.
  - IDLE -> RUN: on start=1 with count!=0. Latch remaining=count and clear words_out.
  - IDLE -> DONE: on start=1 with count==0. No FIFO reads occur.
  - RUN -> DONE: when words_out reaches the latched count. This happens on the handshake of the last word.
  - DONE -> IDLE: unconditionally after one cycle. done=1 only in DONE.
  - start is ignored outside IDLE.
- Read issue (combinational), fifo_deq = state==RUN && !fifo_empty && remaining!=0 && (occ + inflight - pop) < 2.
  - occ: number of buffer entries (0..2).
  - inflight: a deq was issued last cycle.
  - pop: m_valid && m_ready.
  - Each deq decrements remaining and sets inflight for the next cycle.
- Capture: when inflight=1, fifo_data_out is written into the buffer tail at the end of that cycle. The occupancy rule guarantees the buffer never overflows.
- Stream output:
  - m_valid = occ!=0; m_data = buffer head.
  - m_data and m_valid are held stable while m_valid && !m_ready.
  - Each handshake pops the head and increments words_out.
- Latency: deq issued at cycle t gives fifo_data_out valid at t+1, captured at the end of t+1, and m_valid=1 at t+2.
- Throughput: one word per cycle is sustained while the FIFO is non-empty and m_ready=1.
- Simultaneous capture and pop in one cycle: occupancy is unchanged and ordering is preserved.
- FIFO empty mid-burst: deq is withheld and the burst stalls in RUN. It resumes when fifo_empty deasserts, with no timeout.
- m_ready low: at most 2 words are buffered (occ + inflight ≤ 2), then deq is withheld.
- words_out holds its final value after DONE until the next accepted start.

Test Plan:
- Basic burst: FIFO preloaded 0x11,0x22,0x33; start with count=3, m_ready=1.
  - Expect exactly 3 fifo_deq pulses on consecutive cycles, starting 1 cycle after start.
  - m_data 0x11,0x22,0x33 on consecutive cycles, starting 2 cycles after the first deq.
  - done pulses once; words_out=3; busy then falls.
- Backpressure: 5 words preloaded, count=5, m_ready held low for 6 cycles then high.
  - Expect only 2 deq pulses during the stall and m_data stable at word 0.
  - All 5 words delivered in order with no loss or duplication.
- Empty stall: FIFO holds 1 word, count=3. Push 2 more words 10 cycles later.
  - Expect busy=1 and fifo_deq=0 while fifo_empty=1.
  - Burst completes after the pushes; words_out=3.
- Zero count and ignored start:
  - start with count=0 -> done pulses on the next cycle, no deq, words_out=0.
  - A second start pulse during a 4-word burst -> ignored; exactly 4 words delivered.
- Reset mid-burst: assert reset asynchronously (between clock edges) after 2 of 4 words.
  - All outputs go to 0 immediately; state is IDLE.
  - A new start with count=2 delivers the next 2 FIFO words.
